// File: rtl/reg_file_wb.sv
// -----------------------------------------------------------------------------
// reg_file_wb -- architectural register file behind the write-back mux.
//
// A write is captured into a one-entry write-back latch and commits to the
// register array on the following clock edge. The write enable is decoded
// from the same opcode that steers the write-back mux. A retired HALT blocks
// all further captures until reset; a write already in the latch still
// drains. Register 0 is an ordinary register.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   : read ports forward the latch contents when the addresses match
//   undefined : read ports see the array only (one bubble needed after a writer)
//
// Ports
//   clk        in   1       clock, rising edge
//   reset      in   1       asynchronous, active-high reset
//   wb_data_i  in   DATA_W  write-back byte from the write-back mux
//   opcode     in   4       opcode of the instruction in write-back
//   wb_valid   in   1       opcode / wb_data_i / wr_addr valid this cycle
//   wr_addr    in   ADDR_W  destination register
//   rd_addr_a  in   ADDR_W  read port A address
//   rd_addr_b  in   ADDR_W  read port B address
//   rd_data_a  out  DATA_W  read port A data (combinational)
//   rd_data_b  out  DATA_W  read port B data (combinational)
//   wr_pending out  1       write-back latch holds an uncommitted write
//   halted     out  1       HALT retired; further writes blocked
// -----------------------------------------------------------------------------
module reg_file_wb #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic [3:0]        opcode,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              wr_pending,
  output logic              halted
);

  // The array spans the full address space so any read index is legal;
  // entries at or above NUM_REGS are never written and stay at reset value.
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [3:0] OP_HALT = 4'b1110;

  function automatic logic is_write_op(input logic [3:0] op);
    case (op)
      4'b0111, 4'b1000, 4'b1001, 4'b1101, 4'b0000,
      4'b0001, 4'b0101, 4'b0110, 4'b0100: is_write_op = 1'b1;
      default:                            is_write_op = 1'b0;
    endcase
  endfunction

  logic [DATA_W-1:0] arr_q [DEPTH];

  logic              wb_we_q,   wb_we_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              halted_q,  halted_d;

  logic capture;
  logic halt_hit;

  // wb_valid gates every use of opcode/wr_addr/wb_data_i so unknowns on an
  // idle bus cannot reach state. Address/data hold when nothing is captured.
  always_comb begin
    capture   = wb_valid && is_write_op(opcode) && !halted_q &&
                (32'(wr_addr) < NUM_REGS);
    halt_hit  = wb_valid && (opcode == OP_HALT);
    wb_we_d   = capture;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    if (capture) begin
      wb_addr_d = wr_addr;
      wb_data_d = wb_data_i;
    end
    halted_d  = halted_q || halt_hit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        arr_q[i] <= '0;
      end
      wb_we_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      halted_q  <= 1'b0;
    end else begin
      // Commit of the previous capture is independent of this edge's capture,
      // so a write sitting in the latch drains even on the HALT edge.
      if (wb_we_q) begin
        arr_q[wb_addr_q] <= wb_data_q;
      end
      wb_we_q   <= wb_we_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      halted_q  <= halted_d;
    end
  end

  logic [DATA_W-1:0] arr_a, arr_b;

  assign arr_a = (32'(rd_addr_a) < NUM_REGS) ? arr_q[rd_addr_a] : '0;
  assign arr_b = (32'(rd_addr_b) < NUM_REGS) ? arr_q[rd_addr_b] : '0;

`ifdef REGFILE_BYPASS_EN
  // wb_addr_q is always in range while wb_we_q is set, so a match implies
  // an in-range read address.
  always_comb begin
    rd_data_a = arr_a;
    rd_data_b = arr_b;
    if (wb_we_q && (rd_addr_a == wb_addr_q)) rd_data_a = wb_data_q;
    if (wb_we_q && (rd_addr_b == wb_addr_q)) rd_data_b = wb_data_q;
  end
`else
  always_comb begin
    rd_data_a = arr_a;
    rd_data_b = arr_b;
  end
`endif

  assign wr_pending = wb_we_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_reg_file_wb.sv
module tb_reg_file_wb;

  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 8;
  localparam int ADDR_W   = 4;

  localparam logic [3:0] OP_ADD = 4'b0111;
  localparam logic [3:0] OP_SUB = 4'b1000;
  localparam logic [3:0] OP_LIM = 4'b0100;
  localparam logic [3:0] OP_STR = 4'b0011;
  localparam logic [3:0] OP_BEQ = 4'b1011;
  localparam logic [3:0] OP_HLT = 4'b1110;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] wb_data_i;
  logic [3:0]        opcode;
  logic              wb_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              wr_pending;
  logic              halted;

  reg_file_wb #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .wb_data_i (wb_data_i),
    .opcode    (opcode),
    .wb_valid  (wb_valid),
    .wr_addr   (wr_addr),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .wr_pending(wr_pending),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Architectural view: committed register values plus a queue of writes
  // accepted but not yet visible in the array.
  typedef struct {
    int              addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic [DATA_W-1:0] marr [NUM_REGS];
  wr_t               pend [$];
  bit                mhalt;

  function automatic bit writes_reg(input logic [3:0] op);
    return op inside {4'b0111, 4'b1000, 4'b1001, 4'b1101, 4'b0000,
                      4'b0001, 4'b0101, 4'b0110, 4'b0100};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) marr[i] = '0;
    pend.delete();
    mhalt = 1'b0;
  endtask

  task automatic model_edge();
    bit  was_halted;
    wr_t w;
    was_halted = mhalt;
    if (pend.size() > 0) begin
      w = pend.pop_front();
      marr[w.addr] = w.data;
    end
    if (wb_valid && opcode == OP_HLT) mhalt = 1'b1;
    if (wb_valid && writes_reg(opcode) && !was_halted && int'(wr_addr) < NUM_REGS) begin
      w.addr = int'(wr_addr);
      w.data = wb_data_i;
      pend.push_back(w);
    end
  endtask

  function automatic logic [DATA_W-1:0] exp_rd(input logic [ADDR_W-1:0] a);
    if (int'(a) >= NUM_REGS) return '0;
`ifdef REGFILE_BYPASS_EN
    if (pend.size() > 0 && pend[0].addr == int'(a)) return pend[0].data;
`endif
    return marr[int'(a)];
  endfunction

  task automatic check_outputs(input string pfx);
    chk({pfx, "_rd_a"},    32'(rd_data_a),  32'(exp_rd(rd_addr_a)));
    chk({pfx, "_rd_b"},    32'(rd_data_b),  32'(exp_rd(rd_addr_b)));
    chk({pfx, "_pending"}, 32'(wr_pending), 32'(pend.size() > 0));
    chk({pfx, "_halted"},  32'(halted),     32'(mhalt));
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [ADDR_W-1:0] wa,
                       input logic [DATA_W-1:0] wd, input logic [ADDR_W-1:0] ra,
                       input logic [ADDR_W-1:0] rb);
    wb_valid  = v;
    opcode    = op;
    wr_addr   = wa;
    wb_data_i = wd;
    rd_addr_a = ra;
    rd_addr_b = rb;
  endtask

  task automatic tick(input string pfx);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(pfx);
  endtask

  // Reset asserted between clock edges; outputs must clear without a clock.
  task automatic async_reset(input string pfx);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_outputs(pfx);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [ADDR_W-1:0] last_wa;
    reset = 1'b1;
    drive(1'b0, 4'h0, '0, '0, '0, '0);
    model_reset();

    // Test 1: every address reads zero after reset
    #12;
    for (int i = 0; i < 16; i++) begin
      rd_addr_a = 4'(i);
      rd_addr_b = 4'(15 - i);
      #1;
      chk("t1_rd_a", 32'(rd_data_a), 32'h0);
      chk("t1_rd_b", 32'(rd_data_b), 32'h0);
    end
    chk("t1_pending", 32'(wr_pending), 32'h0);
    chk("t1_halted",  32'(halted),     32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Test 2: LIM r3 = 0x5A, visible after the commit edge in either build
    drive(1'b1, OP_LIM, 4'd3, 8'h5A, 4'd3, 4'd3);
    tick("t2e1");
`ifdef REGFILE_BYPASS_EN
    chk("t2_e1_const", 32'(rd_data_a), 32'h5A);
`else
    chk("t2_e1_const", 32'(rd_data_a), 32'h00);
`endif
    drive(1'b0, 4'h0, '0, '0, 4'd3, 4'd3);
    tick("t2e2");
    chk("t2_e2_const", 32'(rd_data_a), 32'h5A);

    // Test 3: STR / BEQ never write
    drive(1'b1, OP_STR, 4'd2, 8'hFF, 4'd2, 4'd2);
    tick("t3str");
    chk("t3_str_pend", 32'(wr_pending), 32'h0);
    drive(1'b1, OP_BEQ, 4'd2, 8'hFF, 4'd2, 4'd2);
    tick("t3beq");
    chk("t3_beq_pend", 32'(wr_pending), 32'h0);
    drive(1'b0, 4'h0, '0, '0, 4'd2, 4'd2);
    tick("t3idle");
    chk("t3_r2_const", 32'(rd_data_a), 32'h00);

    // Test 4: back-to-back writes to r1, later one wins
    drive(1'b1, OP_ADD, 4'd1, 8'h11, 4'd1, 4'd1);
    tick("t4a");
`ifdef REGFILE_BYPASS_EN
    chk("t4_between_const", 32'(rd_data_a), 32'h11);
`endif
    drive(1'b1, OP_SUB, 4'd1, 8'h22, 4'd1, 4'd1);
    tick("t4b");
    drive(1'b0, 4'h0, '0, '0, 4'd1, 4'd1);
    tick("t4c");
    chk("t4_r1_const", 32'(rd_data_a), 32'h22);

    // Test 5: write drains across HALT, later LIM dropped
    drive(1'b1, OP_ADD, 4'd4, 8'h77, 4'd4, 4'd4);
    tick("t5add");
    drive(1'b1, OP_HLT, 4'd0, 8'h00, 4'd4, 4'd4);
    tick("t5hlt");
    drive(1'b1, OP_LIM, 4'd4, 8'h01, 4'd4, 4'd4);
    tick("t5lim");
    drive(1'b0, 4'h0, '0, '0, 4'd4, 4'd4);
    tick("t5idle");
    chk("t5_r4_const",   32'(rd_data_a),  32'h77);
    chk("t5_halt_const", 32'(halted),     32'h1);
    chk("t5_pend_const", 32'(wr_pending), 32'h0);

    // Test 6: reset discards an in-flight write immediately
    async_reset("t6pre");
    drive(1'b1, OP_LIM, 4'd5, 8'h99, 4'd5, 4'd5);
    tick("t6cap");
    chk("t6_pend_const", 32'(wr_pending), 32'h1);
    async_reset("t6rst");
    chk("t6_pend_drop", 32'(wr_pending), 32'h0);
    chk("t6_r5_rst",    32'(rd_data_a),  32'h00);
    drive(1'b0, 4'h0, '0, '0, 4'd5, 4'd5);
    tick("t6idle");
    chk("t6_r5_const", 32'(rd_data_a), 32'h00);

    // Randomized traffic: all opcodes, out-of-range addresses, rare HALT,
    // reads biased toward the last destination to exercise the pending cycle.
    last_wa = '0;
    for (int n = 0; n < 800; n++) begin
      logic       v;
      logic [3:0] op;
      logic [3:0] wa;
      logic [3:0] ra;
      logic [3:0] rb;
      v  = ($urandom % 4) != 0;
      op = 4'($urandom % 16);
      if (op == OP_HLT && ($urandom % 12) != 0) op = OP_STR;
      wa = 4'(($urandom % 4 == 0) ? $urandom % 16 : $urandom % NUM_REGS);
      ra = ($urandom % 2) ? last_wa : 4'($urandom % 16);
      rb = ($urandom % 2) ? wa      : 4'($urandom % 16);
      drive(v, op, wa, 8'($urandom), ra, rb);
      tick("rnd");
      last_wa = wa;
      if ((n % 150) == 149 || (mhalt && ($urandom % 6) == 0)) begin
        drive(1'b0, 4'h0, '0, '0, last_wa, 4'($urandom % NUM_REGS));
        async_reset("rndrst");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
